mem_wb_stage_reg: RTL
=====================

// Module: mem_wb_stage_reg
// PURPOSE
//  Parametrised MEM->WB pipeline stage register for the RV32IM core.
//  - Adds valid/ready handshake, a 2-entry skid buffer, synchronous flush and x0-write suppression.
//  - Defines reset values for all outputs (no X on reset).
//  - Sits between the data-memory stage and the register-file writeback port.
//  - Also drives the WB forwarding source for the hazard unit.
// PARAMETERS
//  XLEN     32  data width of memory-read and ALU-result payloads
//  RADDR_W  5   destination register address width
//  SKID     1   1 = 2-entry skid buffer (fully registered ready); 0 = single register, pass-through ready
// PORTS
//  CLK             in   1        rising-edge clock
//  Reset_n         in   1        asynchronous, active-low reset
//  in_valid        in   1        MEM stage presents a valid instruction
//  in_ready        out  1        stage can accept this cycle
//  in_reg_write    in   1        instruction writes rd
//  in_mem_to_reg   in   1        1 = writeback selects memory data, 0 = ALU result
//  in_mem_data     in   XLEN     data-memory read value
//  in_alu_result   in   XLEN     ALU result / address
//  in_rd           in   RADDR_W  destination register
//  flush           in   1        discard all held and incoming entries
//  out_valid       out  1        head entry valid toward WB
//  out_ready       in   1        WB consumes head this cycle
//  out_reg_write   out  1        head writes rd (already gated for rd==0)
//  out_rd          out  RADDR_W  head destination register
//  wb_data         out  XLEN     head writeback value (mux of mem_data/alu_result by mem_to_reg)
//  fwd_valid       out  1        out_valid & out_reg_write (forwarding qualifier)
//  occupancy       out  2        entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  - Transfer events: push = in_valid & in_ready; pop = out_valid & out_ready.
//  - Reset (Reset_n low, async):
//    - state EMPTY; all payload registers cleared to 0.
//    - out_valid=0, out_reg_write=0, fwd_valid=0, occupancy=0, wb_data=0, out_rd=0.
//    - in_ready=1 when SKID=1.
//    - Assertion mid-transfer drops every in-flight entry.
//  - SKID=1 state machine (head slot H, skid slot S), FIFO order:
//    - EMPTY: push -> ONE (load H).
//    - ONE: push&!pop -> FULL (load S); !push&pop -> EMPTY; push&pop -> ONE (load H with input).
//    - FULL: pop -> ONE (S moves to H); no push possible.
//    - in_ready = (state != FULL); driven from a flop, no combinational path from out_ready.
//  - SKID=0: single slot H; in_ready = !out_valid | out_ready (combinational).
//  - Latency: 1 cycle from push to out_valid when empty.
//  - Payload is held stable while out_valid & !out_ready (stall).
//  - Flush (synchronous, highest priority):
//    - next state EMPTY; a push in the same cycle is discarded.
//    - A pop in the same cycle still completes (WB already committed).
//    - out_valid=0 from the next edge.
//  - x0 rule: out_reg_write is captured as in_reg_write & (in_rd != 0).
//    - out_rd and the payload are still passed through unchanged.
//  - wb_data and fwd_valid are combinational from H only; S is never visible on outputs.
//  - occupancy reflects the registered state: EMPTY=0, ONE=1, FULL=2.
// STRUCTURE
//  - Package rv32_pipe_pkg:
//    - typedef mem_wb_payload_t {reg_write, mem_to_reg, mem_data, alu_result, rd}
//    - enum skid_state_t {EMPTY, ONE, FULL}
//    - localparam REG_ZERO
//  - Sub-module pipe_payload_reg: load-enabled, async-clear register of mem_wb_payload_t.
//    - Instantiated for H always and for S under generate when SKID=1.
//  - FSM and ready/valid logic live in this module.
// TESTING
//  1. Reset_n=0 mid-stream with 2 entries held -> immediately out_valid=0, occupancy=0, wb_data=0; in_ready=1 after release.
//  2. Push rd=5, alu=0x0000_1234, mem_to_reg=0, out_ready=1 -> next cycle out_valid=1, wb_data=0x0000_1234, fwd_valid=1.
//  3. out_ready=0; push A (alu=0xA), then B (alu=0xB) -> occupancy=2, in_ready=0; raise out_ready -> A then B in order, no loss or duplicate.
//  4. Push rd=0, reg_write=1, mem_data=0xDEAD_BEEF, mem_to_reg=1 -> out_valid=1, wb_data=0xDEAD_BEEF, out_reg_write=0, fwd_valid=0.
//  5. FULL state, flush=1 with in_valid=1 and out_ready=1 -> head popped that cycle, next cycle occupancy=0, incoming entry never appears.
//  6. SKID=0 build, random in_valid/out_ready for 1000 cycles -> scoreboard order and data match, occupancy never exceeds 1.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// Shared types for the RV32IM pipeline stage registers.
package rv32_pipe_pkg;

  localparam int PIPE_XLEN    = 32;
  localparam int PIPE_RADDR_W = 5;

  localparam logic [PIPE_RADDR_W-1:0] REG_ZERO = '0;

  // One MEM->WB entry. The field widths here set the widths that the stage registers store.
  typedef struct packed {
    logic                    reg_write;
    logic                    mem_to_reg;
    logic [PIPE_XLEN-1:0]    mem_data;
    logic [PIPE_XLEN-1:0]    alu_result;
    logic [PIPE_RADDR_W-1:0] rd;
  } mem_wb_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_occ(input skid_state_t s);
    case (s)
      ONE:     state_occ = 2'd1;
      FULL:    state_occ = 2'd2;
      default: state_occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with asynchronous clear.
module pipe_payload_reg
  import rv32_pipe_pkg::*;
#(
  parameter type T = mem_wb_payload_t
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic load,
  input  T     d,
  output T     q
);

  // Capture d when load is high; clear to all-zero on reset.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM->WB stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and x0-write suppression.
//
//  state | meaning
//  EMPTY | no entry held, out_valid low
//  ONE   | head slot H valid, skid slot S free
//  FULL  | H and S both valid, in_ready low (SKID=1 only)
module mem_wb_stage_reg
  import rv32_pipe_pkg::*;
#(
  parameter int XLEN    = PIPE_XLEN,
  parameter int RADDR_W = PIPE_RADDR_W,
  parameter int SKID    = 1
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_reg_write,
  input  logic               in_mem_to_reg,
  input  logic [XLEN-1:0]    in_mem_data,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_reg_write,
  output logic [RADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic               fwd_valid,
  output logic [1:0]         occupancy
);

  skid_state_t     state, state_nxt;
  logic            rdy_q, vld_q;
  logic [1:0]      occ_q;
  logic            push, pop;
  logic            h_load, h_from_s, s_load;
  mem_wb_payload_t in_pl, h_d, h_q, s_q;

  // With the skid buffer, ready comes straight from a flop; otherwise it
  // passes through from out_ready.
  assign in_ready = (SKID != 0) ? rdy_q : (!vld_q | out_ready);
  assign push     = in_valid & in_ready;
  assign pop      = vld_q & out_ready;

  // Incoming entry, with writes to x0 suppressed at capture.
  always_comb begin
    in_pl            = '0;
    in_pl.reg_write  = in_reg_write & (in_rd != REG_ZERO);
    in_pl.mem_to_reg = in_mem_to_reg;
    in_pl.mem_data   = in_mem_data;
    in_pl.alu_result = in_alu_result;
    in_pl.rd         = in_rd;
  end

  // Next-state decode; flush overrides everything.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (SKID != 0) begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = FULL;
          else if (!push && pop) state_nxt = EMPTY;
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end else begin
      if (push)     state_nxt = ONE;
      else if (pop) state_nxt = EMPTY;
    end
  end

  // State register; ready, valid and occupancy are registered alongside it.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != FULL);
      vld_q <= (state_nxt != EMPTY);
      occ_q <= state_occ(state_nxt);
    end
  end

  // H takes the input when empty or when the head leaves in the same cycle.
  // H refills from S when a pop happens in FULL.
  // S captures when a push lands behind a stalled head.
  always_comb begin
    h_load   = push & !flush & ((state == EMPTY) | pop);
    h_from_s = (SKID != 0) & (state == FULL) & pop & !flush;
    s_load   = (SKID != 0) & push & !flush & (state == ONE) & !pop;
    h_d      = h_from_s ? s_q : in_pl;
  end

  pipe_payload_reg #(.T(mem_wb_payload_t)) u_head (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .load    (h_load | h_from_s),
    .d       (h_d),
    .q       (h_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_payload_reg #(.T(mem_wb_payload_t)) u_skid (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .load    (s_load),
        .d       (in_pl),
        .q       (s_q)
      );
    end else begin : g_no_skid
      assign s_q = '0;
    end
  endgenerate

  // Outputs come from H only; S never reaches them.
  assign out_valid     = vld_q;
  assign out_reg_write = vld_q & h_q.reg_write;
  assign fwd_valid     = vld_q & h_q.reg_write;
  assign out_rd        = h_q.rd;
  assign wb_data       = h_q.mem_to_reg ? h_q.mem_data : h_q.alu_result;
  assign occupancy     = occ_q;

endmodule
